// File: rtl/regfile_pkg.sv
// Shared defaults for the register-file write path: widths, the hard-wired zero register,
// and a pointer-width helper used by the arbiter and its top level.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin priority pick: rotate the request vector by the pointer, take the lowest
// set bit, and map it back to the original requester index.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);
    logic [PW-1:0] rot_idx [N];
    logic [N-1:0]  rot_req;
    logic          found;

    // rot_idx[k] = (ptr + k) mod N; ptr is always < N so one conditional subtract suffices
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [PW:0] sum;
            assign sum          = {1'b0, ptr} + (PW+1)'(gi);
            assign rot_idx[gi]  = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
            assign rot_req[gi]  = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot_req[k]) begin
                found = 1'b1;
                idx   = rot_idx[k];
            end
        end
        grant = found ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among N_REQ write-back sources: round-robin grant,
// one registered output stage that drops $0 writes, and forwarding of the write in flight.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [ADDR_W-1:0]        rs_addr,
    input  logic [ADDR_W-1:0]        rt_addr,
    output logic                     fwd_rs_hit,
    output logic                     fwd_rt_hit,
    output logic [DATA_W-1:0]        fwd_data
);
    localparam int PW = ptr_w(N_REQ);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic              xfer;
    logic              rf_we_reg;
    logic [ADDR_W-1:0] rf_addr_reg;
    logic [DATA_W-1:0] rf_wdata_reg;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (gnt_idx)
    );

    // No grants while reset is asserted, so nothing is accepted that would then be lost silently
    always_comb begin
        req_ready = (rst_n && !hold) ? grant : '0;
        xfer      = |(req_valid & req_ready);
        ptr_next  = ptr_reg;
        if (xfer) begin
            ptr_next = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            rf_we_reg    <= 1'b0;
            rf_addr_reg  <= '0;
            rf_wdata_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            rf_we_reg <= xfer && (addr_arr[gnt_idx] != ZERO_ADDR);
            if (xfer) begin
                rf_addr_reg  <= addr_arr[gnt_idx];
                rf_wdata_reg <= data_arr[gnt_idx];
            end
        end
    end

    assign rf_we      = rf_we_reg;
    assign rf_addr    = rf_addr_reg;
    assign rf_wdata   = rf_wdata_reg;
    assign fwd_data   = rf_wdata_reg;
    assign fwd_rs_hit = rf_we_reg && (rf_addr_reg == rs_addr) && (rs_addr != ZERO_ADDR);
    assign fwd_rt_hit = rf_we_reg && (rf_addr_reg == rt_addr) && (rt_addr != ZERO_ADDR);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes go into a scoreboard queue
// when a grant is checked; a monitor pops and compares whenever rf_we is presented.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hold = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [4:0]  a_tb [3];
    logic [31:0] d_tb [3];
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic        fwd_rs_hit, fwd_rt_hit;
    logic [31:0] fwd_data;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int r2_wait = 0;
    bit proto_en = 1'b0;

    assign req_addr = {a_tb[2], a_tb[1], a_tb[0]};
    assign req_data = {d_tb[2], d_tb[1], d_tb[0]};

    always #5 clk = ~clk;

    regfile_write_arbiter #(.N_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .fwd_rs_hit (fwd_rs_hit),
        .fwd_rt_hit (fwd_rt_hit),
        .fwd_data   (fwd_data)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // One cycle: check the grant mid-cycle, queue the write it should produce, advance.
    task automatic step(input logic [2:0] exp_ready, input string name);
        @(negedge clk);
        check(name, 32'(req_ready), 32'(exp_ready));
        for (int i = 0; i < 3; i++) begin
            if (exp_ready[i] && a_tb[i] != 5'd0) exp_q.push_back('{a: a_tb[i], d: d_tb[i]});
        end
        if (req_valid[2]) r2_wait++;
        if (req_ready[2]) begin
            check("fair_r2_wait_le3", 32'(r2_wait <= 3), 32'd1);
            r2_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented write must match the oldest expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rf_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr %0d data %h required no write", rf_addr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rf_addr !== e.a || rf_wdata !== e.d) begin
                        errors++;
                        $display("FAIL wr_commit: got addr %0d data %h required addr %0d data %h",
                                 rf_addr, rf_wdata, e.a, e.d);
                    end else begin
                        $display("ok   wr_commit: addr %0d data %h", rf_addr, rf_wdata);
                    end
                end
            end
        end
    end

    // Writes accepted around a reset never reach the register file.
    always @(negedge rst_n) exp_q.delete();

    // Handshake rule: a pending (valid, not yet accepted) request must stay stable.
    initial begin
        logic [2:0]  pend;
        logic [4:0]  pa [3];
        logic [31:0] pd [3];
        pend = '0;
        forever begin
            @(posedge clk);
            if (proto_en && rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    if (pend[i] && (!req_valid[i] || a_tb[i] !== pa[i] || d_tb[i] !== pd[i])) begin
                        errors++;
                        $display("FAIL protocol_withdraw: requester %0d changed before accept", i);
                    end
                end
            end
            pend = rst_n ? (req_valid & ~req_ready) : 3'b000;
            for (int i = 0; i < 3; i++) begin
                pa[i] = a_tb[i];
                pd[i] = d_tb[i];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            a_tb[i] = '0;
            d_tb[i] = '0;
        end
        #2 rst_n = 1'b0;
        req_valid = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        @(posedge clk);
        #1;

        // Round robin across three continuously valid requesters
        a_tb[0] = 5'd5; d_tb[0] = 32'hAAAA_000A;
        a_tb[1] = 5'd6; d_tb[1] = 32'hBBBB_000B;
        a_tb[2] = 5'd7; d_tb[2] = 32'hCCCC_000C;
        rst_n = 1'b1;
        proto_en = 1'b1;
        step(3'b001, "rr_g0");
        step(3'b010, "rr_g1");
        step(3'b100, "rr_g2");
        step(3'b001, "rr_g0b");
        step(3'b010, "rr_g1b");
        step(3'b100, "rr_g2b");
        step(3'b001, "rr_g0c");

        // Mid-run asynchronous reset: pointer (now 1) must return to 0
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'b001, "post_rst_g0");
        proto_en = 1'b0;
        req_valid = 3'b000;
        step(3'b000, "idle0");
        proto_en = 1'b1;

        // $0 write: accepted but never committed
        a_tb[1] = 5'd0; d_tb[1] = 32'hDEAD_BEEF;
        req_valid = 3'b010;
        step(3'b010, "zero_g1");
        req_valid = 3'b000;
        rs_addr = 5'd0;
        @(negedge clk);
        check("zero_rf_we", 32'(rf_we), 32'd0);
        check("zero_fwd_rs", 32'(fwd_rs_hit), 32'd0);
        @(posedge clk);
        #1;

        // Hold: in-flight write drains, pointer (1) is frozen, grant resumes there
        a_tb[0] = 5'd12; d_tb[0] = 32'h0C0C_0C0C;
        req_valid = 3'b001;
        step(3'b001, "hold_pre_g0");
        a_tb[0] = 5'd3; d_tb[0] = 32'h3333_0003;
        a_tb[1] = 5'd4; d_tb[1] = 32'h4444_0004;
        req_valid = 3'b011;
        hold = 1'b1;
        step(3'b000, "hold_c1");
        step(3'b000, "hold_c2");
        check("hold_rf_we", 32'(rf_we), 32'd0);
        step(3'b000, "hold_c3");
        hold = 1'b0;
        step(3'b010, "hold_rel_g1");
        req_valid = 3'b001;
        step(3'b001, "hold_rel_g0");
        req_valid = 3'b000;

        // Forwarding of the write in its commit cycle
        a_tb[0] = 5'd9; d_tb[0] = 32'h1234_5678;
        req_valid = 3'b001;
        step(3'b001, "fwd_g0");
        req_valid = 3'b000;
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        @(negedge clk);
        check("fwd_rs_hit", 32'(fwd_rs_hit), 32'd1);
        check("fwd_rt_hit", 32'(fwd_rt_hit), 32'd1);
        check("fwd_data", fwd_data, 32'h1234_5678);
        rs_addr = 5'd0;
        #1;
        check("fwd_rs_zero", 32'(fwd_rs_hit), 32'd0);
        check("fwd_rt_still", 32'(fwd_rt_hit), 32'd1);
        @(posedge clk);
        #1;
        rt_addr = 5'd0;

        // Fairness: requester 2 held valid while 0/1 come and go (pointer starts at 1)
        a_tb[0] = 5'd1;  d_tb[0] = 32'h0101_0101;
        a_tb[1] = 5'd2;  d_tb[1] = 32'h0202_0202;
        a_tb[2] = 5'd20; d_tb[2] = 32'h1414_1414;
        r2_wait = 0;
        req_valid = 3'b111;
        step(3'b010, "fair_c1");
        req_valid = 3'b101;
        step(3'b100, "fair_c2");
        req_valid = 3'b111;
        step(3'b001, "fair_c3");
        req_valid = 3'b110;
        step(3'b010, "fair_c4");
        req_valid = 3'b101;
        step(3'b100, "fair_c5");
        proto_en = 1'b0;
        req_valid = 3'b000;
        step(3'b000, "drain0");
        step(3'b000, "drain1");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
